ntt_pipe_ctrl: RTL and testbench
================================

NTT_PIPE_CTRL -- requirements
Module: ntt_pipe_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 5: enabled-cycle latency of the butterfly pipeline including its output delay line.
REQ-002 SHALL have parameter WORDS, default 64: 96-bit words per polynomial (4 x 24-bit coefficients).
REQ-003 SHALL have parameter PASSES, default 4: passes per transform.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic rises on posedge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: begin a transform; sampled only in IDLE.
REQ-007 SHALL have port stall, input, 1: memory-port conflict; freezes all progress while high.
REQ-008 SHALL have port rd_en / rd_addr, output, 1 / clog2(WORDS): memory read request and word address.
REQ-009 SHALL have port pipe_en, output, 1: enable driven to the datapath and its delay lines.
REQ-010 SHALL have port wr_en / wr_addr, output, 1 / clog2(WORDS): memory write-back request and word address.
REQ-011 SHALL have port pass_idx, output, clog2(PASSES): current pass, selects twiddles and stride.
REQ-012 SHALL have ports busy and done, output, 1 each: busy high outside IDLE; done a one-cycle pulse at completion.

Function
REQ-013 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-014 IDLE->ISSUE on start=1; rd_addr=0, pass_idx=0, in-flight count=0.
REQ-015 In ISSUE with stall=0: rd_en=1, rd_addr increments each cycle from 0 to WORDS-1; ISSUE->DRAIN after address WORDS-1 is issued.
REQ-016 Memory read latency is 1 cycle; wr_en SHALL assert exactly DEPTH+1 non-stalled cycles after the rd_en of the same word, with wr_addr equal to that word's rd_addr.
REQ-017 pipe_en SHALL equal busy AND NOT stall; while stall=1, rd_en=0, wr_en=0, and all counters, addresses and delay tracking hold.
REQ-018 In DRAIN, no reads; leave DRAIN when the write of word WORDS-1 completes: if pass_idx<PASSES-1, increment pass_idx, rd_addr=0, go to ISSUE; else go to DONE.
REQ-019 No read of pass p+1 SHALL be issued before the last write of pass p (read-after-write hazard).
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE; start in DONE is ignored.
REQ-021 start while busy SHALL be ignored.
REQ-022 rd_addr/wr_addr SHALL not wrap beyond WORDS-1 within a pass; wrap to 0 only at pass boundaries.
REQ-023 Total transform with no stalls SHALL take PASSES*(WORDS+DEPTH+1)+1 cycles from start to done.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, with rd_en, wr_en, pipe_en, busy, done=0 and rd_addr, wr_addr, pass_idx=0.
REQ-025 Reset mid-transform SHALL abandon all in-flight words; no wr_en after release until a new start.

Configuration
REQ-026 Macro NTT_CTRL_ABORT_EN, when defined, SHALL add input abort (1 bit): abort=1 in any non-IDLE state forces IDLE next cycle, clears in-flight tracking, done not pulsed; abort has priority over stall.
REQ-027 Without NTT_CTRL_ABORT_EN, the abort port SHALL not exist and behaviour is as REQ-013..025.

Verification
REQ-028 Defaults, start pulse, stall=0 -> 64 rd_en per pass, first wr_en 6 cycles after first rd_en, pass_idx 0..3, done at cycle 281.
REQ-029 stall held 3 cycles mid-ISSUE at rd_addr=10 -> rd_en, wr_en, pipe_en low for exactly 3 cycles, addresses resume at 10, done delayed 3 cycles.
REQ-030 Pass boundary -> first rd_en of pass 1 strictly after wr_en of word 63 of pass 0.
REQ-031 rst_n low at pass 2 word 30 -> all outputs 0 immediately; no wr_en after release; fresh start completes normally.
REQ-032 start re-pulsed while busy and in DONE -> ignored; exactly one done.
REQ-033 With NTT_CTRL_ABORT_EN, abort in DRAIN of pass 1 -> IDLE next cycle, busy=0, no done, no further wr_en.

Source files
------------

// File: rtl/ntt_pipe_ctrl_if.sv
// Controller-side bundle for the NTT pipeline: start/stall handshake, memory
// read/write requests, datapath enable and pass select.
interface ntt_pipe_ctrl_if #(
  parameter int WORDS  = 64,
  parameter int PASSES = 4
);
  localparam int AW = (WORDS  > 1) ? $clog2(WORDS)  : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  logic          start;
  logic          stall;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          pipe_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] pass_idx;
  logic          busy;
  logic          done;

  modport master (
    input  start, stall,
    output rd_en, rd_addr, pipe_en, wr_en, wr_addr, pass_idx, busy, done
  );

  modport slave (
    output start, stall,
    input  rd_en, rd_addr, pipe_en, wr_en, wr_addr, pass_idx, busy, done
  );
endinterface

// File: rtl/ntt_pipe_ctrl.sv
// Read/issue/drain sequencer for a multi-pass NTT butterfly pipeline.
// Optional NTT_CTRL_ABORT_EN adds an abort input that returns to IDLE at once.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// ISSUE | one read per non-stalled cycle, words 0..WORDS-1
// DRAIN | no reads, waiting for the pass's last write-back
// DONE  | one-cycle done pulse, then IDLE
module ntt_pipe_ctrl #(
  parameter int DEPTH  = 5,
  parameter int WORDS  = 64,
  parameter int PASSES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef NTT_CTRL_ABORT_EN
  input  logic           abort,
`endif
  ntt_pipe_ctrl_if.master bus
);

  localparam int AW = (WORDS  > 1) ? $clog2(WORDS)  : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int VW = DEPTH + 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state;
  logic          rd_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] pass_idx;
  logic [VW-1:0] vld;

  logic stall;
  logic kill;
  logic last_wr;

  assign stall = bus.stall;

`ifdef NTT_CTRL_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  // vld[DEPTH] marks a word leaving the delay line (read latency + DEPTH)
  assign last_wr = vld[DEPTH] && !stall && (wr_addr == LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      pass_idx <= '0;
      vld      <= '0;
    end else if (kill) begin
      state    <= IDLE;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      pass_idx <= '0;
      vld      <= '0;
    end else begin
      if (!stall) begin
        vld <= (vld << 1) | VW'(rd_q);
        if (vld[DEPTH])
          wr_addr <= (wr_addr == LAST_WORD) ? '0 : wr_addr + AW'(1);
      end

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ISSUE;
            rd_q     <= 1'b1;
            busy_q   <= 1'b1;
            rd_addr  <= '0;
            wr_addr  <= '0;
            pass_idx <= '0;
            vld      <= '0;
          end
        end
        ISSUE: begin
          if (!stall) begin
            if (rd_addr == LAST_WORD) begin
              state <= DRAIN;
              rd_q  <= 1'b0;
            end else begin
              rd_addr <= rd_addr + AW'(1);
            end
          end
        end
        DRAIN: begin
          // next pass reads only after this pass's final write-back
          if (last_wr) begin
            if (pass_idx == LAST_PASS) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state    <= ISSUE;
              rd_q     <= 1'b1;
              rd_addr  <= '0;
              pass_idx <= pass_idx + PW'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_en    = rd_q & ~stall;
  assign bus.rd_addr  = rd_addr;
  assign bus.wr_en    = vld[DEPTH] & ~stall;
  assign bus.wr_addr  = wr_addr;
  assign bus.pipe_en  = busy_q & ~stall;
  assign bus.pass_idx = pass_idx;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_ntt_pipe_ctrl.sv
// Directed bench for ntt_pipe_ctrl at default parameters: vector table of
// stall scenarios plus reset-mid-transform and (optional) abort sequences.
module tb_ntt_pipe_ctrl;

  logic clk;
  logic rst_n;
`ifdef NTT_CTRL_ABORT_EN
  logic abort;
`endif

  ntt_pipe_ctrl_if #(.WORDS(64), .PASSES(4)) bus ();

  ntt_pipe_ctrl #(.DEPTH(5), .WORDS(64), .PASSES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef NTT_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    int sw;        // rd_addr in pass 0 at which stall rises (-1 = none)
    int sl;        // stall length in cycles
    bit rep;       // re-pulse start while busy and in DONE
    int exp_done;  // cycle of done, start cycle = 0
    int exp_gap;   // first wr_en cycle minus first rd_en cycle
  } vec_t;

  vec_t vecs[6];

  // Inputs change 1ns after posedge; outputs sampled at negedge of the same cycle.
  task automatic run_xfer(input int sw, input int sl, input bit rep,
                          output int done_cyc, output int n_rd, output int n_wr,
                          output int n_done, output int n_stall, output int gap,
                          output int errs);
    int q_ns[$];
    int q_ad[$];
    int cyc, ns, first_rd, first_wr, post, stall_left, t, a;
    bit stall_used;
    done_cyc = -1; n_rd = 0; n_wr = 0; n_done = 0; n_stall = 0; errs = 0;
    cyc = 0; ns = 0; first_rd = -1; first_wr = -1; post = -1;
    stall_left = 0; stall_used = 0;
    while (cyc < 700 && post != 0) begin
      @(posedge clk); #1;
      bus.start = (cyc == 0) || (rep && (cyc == 5 || cyc == 150 || bus.done));
      if (sw >= 0 && !stall_used && cyc > 0 && bus.busy &&
          bus.pass_idx == 2'd0 && int'(bus.rd_addr) == sw) begin
        stall_used = 1;
        stall_left = sl;
      end
      bus.stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      @(negedge clk);
      if (bus.stall) begin
        n_stall++;
        if (bus.rd_en || bus.wr_en || bus.pipe_en) errs++;
      end else if (bus.pipe_en !== bus.busy) errs++;
      if (cyc >= 1 && done_cyc < 0 && !bus.busy) errs++;
      if (bus.rd_en) begin
        if (int'(bus.rd_addr) != n_rd % 64) errs++;
        if (int'(bus.pass_idx) != n_rd / 64) errs++;
        if (n_rd % 64 == 0 && n_rd > 0 && n_wr != n_rd) errs++;
        if (first_rd < 0) first_rd = cyc;
        q_ns.push_back(ns);
        q_ad.push_back(n_rd % 64);
        n_rd++;
      end
      if (bus.wr_en) begin
        if (q_ns.size() == 0) errs++;
        else begin
          t = q_ns.pop_front();
          a = q_ad.pop_front();
          if (int'(bus.wr_addr) != a) errs++;
          if (ns - t != 6) errs++;
        end
        if (int'(bus.pass_idx) != n_wr / 64) errs++;
        if (first_wr < 0) first_wr = cyc;
        n_wr++;
      end
      if (bus.done) begin
        n_done++;
        if (!bus.busy) errs++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          post = 4;
        end
      end
      if (done_cyc >= 0 && cyc > done_cyc && (bus.busy || bus.rd_en || bus.wr_en))
        errs++;
      if (!bus.stall) ns++;
      if (post > 0) post--;
      cyc++;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    gap = first_wr - first_rd;
  endtask

  initial begin
    int d, r, w, nd, ns, g, e, stray;
    bit found;

    vecs[0] = '{sw: -1, sl: 0, rep: 1'b0, exp_done: 281, exp_gap: 6};
    vecs[1] = '{sw: 10, sl: 3, rep: 1'b0, exp_done: 284, exp_gap: 6};
    vecs[2] = '{sw:  2, sl: 4, rep: 1'b0, exp_done: 285, exp_gap: 10};
    vecs[3] = '{sw:  0, sl: 1, rep: 1'b0, exp_done: 282, exp_gap: 6};
    vecs[4] = '{sw: 63, sl: 5, rep: 1'b1, exp_done: 286, exp_gap: 6};
    vecs[5] = '{sw: -1, sl: 0, rep: 1'b1, exp_done: 281, exp_gap: 6};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
`ifdef NTT_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy",    bus.busy,     0);
    chk("rst_done",    bus.done,     0);
    chk("rst_rd_en",   bus.rd_en,    0);
    chk("rst_wr_en",   bus.wr_en,    0);
    chk("rst_pipe_en", bus.pipe_en,  0);
    chk("rst_rd_addr", bus.rd_addr,  0);
    chk("rst_wr_addr", bus.wr_addr,  0);
    chk("rst_pass",    bus.pass_idx, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].sw, vecs[i].sl, vecs[i].rep, d, r, w, nd, ns, g, e);
      chk($sformatf("v%0d_done_cycle", i), d,  vecs[i].exp_done);
      chk($sformatf("v%0d_reads", i),      r,  256);
      chk($sformatf("v%0d_writes", i),     w,  256);
      chk($sformatf("v%0d_done_count", i), nd, 1);
      chk($sformatf("v%0d_stall_cyc", i),  ns, vecs[i].sl);
      chk($sformatf("v%0d_first_gap", i),  g,  vecs[i].exp_gap);
      chk($sformatf("v%0d_seq_errs", i),   e,  0);
    end

    // Reset while pass 2 is reading word 30.
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clk); #1;
      bus.start = (c == 0);
      if (bus.busy && bus.pass_idx == 2'd2 && bus.rd_addr == 6'd30) found = 1;
    end
    bus.start = 1'b0;
    chk("mrst_reached", found, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy",    bus.busy,     0);
    chk("mrst_done",    bus.done,     0);
    chk("mrst_rd_en",   bus.rd_en,    0);
    chk("mrst_wr_en",   bus.wr_en,    0);
    chk("mrst_pipe_en", bus.pipe_en,  0);
    chk("mrst_rd_addr", bus.rd_addr,  0);
    chk("mrst_wr_addr", bus.wr_addr,  0);
    chk("mrst_pass",    bus.pass_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.wr_en || bus.rd_en || bus.busy || bus.done) stray++;
    end
    chk("mrst_quiet_cycles", stray, 0);
    run_xfer(-1, 0, 1'b0, d, r, w, nd, ns, g, e);
    chk("mrst_fresh_done", d, 281);
    chk("mrst_fresh_wr",   w, 256);
    chk("mrst_fresh_errs", e, 0);

`ifdef NTT_CTRL_ABORT_EN
    // Abort in pass 1 DRAIN.
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clk); #1;
      bus.start = (c == 0);
      if (bus.busy && bus.pass_idx == 2'd1 && bus.rd_addr == 6'd63 && !bus.rd_en) found = 1;
    end
    bus.start = 1'b0;
    chk("abort_reached", found, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    stray = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.wr_en || bus.rd_en || bus.done || bus.busy) stray++;
    end
    chk("abort_quiet_cycles", stray, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
